insn_fetch_unit: RTL and testbench
==================================

Name: insn_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the L1 instruction cache.
- Holds the program counter and issues 8-byte-aligned fetch requests into the cache's CPU-side port, accepting read responses back.
- Buffers returned instruction words in a small FIFO for decode.
- Handles branch redirects by flushing the FIFO and discarding the stale in-flight response.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory addresses
- QUEUE_DEPTH, 4, instruction FIFO entries (power of two, >=2)
- RESET_PC, 0, PC loaded on reset (8-byte aligned)
- CORE_ID, 0, value driven on req_source

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  out  1  fetch request to L1 insn cache
- req_ready  in  1  cache can accept request (inverse of its request-busy)
- req_address  out  ADDR_WIDTH  fetch address, low 3 bits always 0
- req_source  out  8  CORE_ID
- resp_valid  in  1  cache response present
- resp_ready  out  1  fetch unit consumes response this cycle
- resp_address  in  ADDR_WIDTH  address of returned line
- resp_payload  in  64  instruction word
- redirect_valid  in  1  branch/exception redirect, single-cycle pulse
- redirect_pc  in  ADDR_WIDTH  new fetch PC
- insn_valid  out  1  FIFO head valid to decode
- insn_ready  in  1  decode accepts head
- insn_pc  out  ADDR_WIDTH  PC of head word
- insn_word  out  64  head instruction word
- fetch_stall  out  1  pulse: FETCH state blocked by FIFO full or !req_ready
- fetch_error  out  1  sticky: response address mismatch

Behaviour:
- Clock/reset: one clock `clk`. Reset is synchronous, active-high: `reset` sampled on the rising edge of `clk`.
- Reset values:
  - State = FETCH; pc = RESET_PC; FIFO empty (count = 0, head/tail = 0); discard = 0.
  - All outputs 0 except req_address = RESET_PC.
  - Reset asserted mid-operation aborts everything; any later response is ignored only if it arrives while in FETCH (resp_ready = 0 there).
- FSM, two states:
  - FETCH: req_valid = (count < QUEUE_DEPTH); req_address = pc.
    - On req_valid && req_ready: pc <= pc + 8 (wraps modulo 2^ADDR_WIDTH); expected_addr <= pc; go WAIT.
    - Otherwise stay. fetch_stall = 1 when count == QUEUE_DEPTH or (req_valid && !req_ready).
  - WAIT: req_valid = 0; resp_ready = 1.
    - On resp_valid: if discard, drop word, clear discard, go FETCH.
    - Else if resp_address != expected_addr: drop, set fetch_error, pc <= expected_addr (refetch), go FETCH.
    - Else push {expected_addr, resp_payload} into FIFO, go FETCH.
- At most one outstanding request. A push never overflows, because issue required count < QUEUE_DEPTH and count only decreases while waiting.
- Latency:
  - First req_valid in the first cycle after reset deasserts.
  - A pushed word appears on insn_valid the cycle after the response handshake.
  - Steady state: one word per 2 cycles plus cache latency.
- FIFO:
  - Circular buffer of QUEUE_DEPTH entries. insn_valid = (count != 0); insn_pc/insn_word driven from head.
  - Pop on insn_valid && insn_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap at QUEUE_DEPTH.
- Redirect (highest priority, any state):
  - pc <= redirect_pc with low 3 bits forced to 0; FIFO flushed (count = 0, pointers reset). A same-cycle pop is ignored and a same-cycle push is dropped.
  - Redirect in WAIT without a same-cycle response: discard <= 1, stay WAIT.
  - Redirect in WAIT with same-cycle response: response consumed and dropped, go FETCH, discard = 0.
  - Redirect in FETCH coinciding with request handshake: request cannot be retracted, so go WAIT with discard <= 1, pc <= aligned redirect_pc.
  - Redirect in FETCH without a handshake: stay FETCH at the new pc.
- fetch_error is cleared only by reset.

Test Plan:
- Reset release, RESET_PC = 0x100, cache responds 2 cycles after each request with payload = address -> requests at 0x100, 0x108, 0x110, 0x118; decode sees insn_pc/insn_word pairs 0x100/0x100, 0x108/0x108, … in order, no gaps or duplicates.
- insn_ready held 0 -> exactly 4 words buffered, then req_valid stays 0 and fetch_stall = 1 every cycle. Raise insn_ready -> fetch resumes at 0x120.
- Redirect to 0x2004 while in WAIT for 0x108 -> 0x108 response dropped, FIFO empty, next request address 0x2000, first decoded insn_pc = 0x2000.
- Redirect in the same cycle as the response handshake, and separately in the same cycle as the request handshake -> the stale word never reaches decode, and the next request is at the redirect target.
- Cache returns resp_address 0x300 when 0x108 was expected -> fetch_error = 1 (sticky), word dropped, request reissued at 0x108.
- pc = 2^32 − 8 fetched -> next request address 0x0. Reset asserted while in WAIT -> all outputs at reset values the next cycle and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit: PC, single-outstanding fetch to the L1 I-cache,
// and a small instruction FIFO feeding decode; redirects flush it.
module insn_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [7:0]            CORE_ID     = 8'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_address,
  output logic [7:0]            req_source,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  input  logic [ADDR_WIDTH-1:0] resp_address,
  input  logic [63:0]           resp_payload,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic [63:0]           insn_word,
  output logic                  fetch_stall,
  output logic                  fetch_error
);

  localparam int            PW      = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0]   LP_FULL = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic {
    S_FETCH,
    S_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nx;
  logic [ADDR_WIDTH-1:0] r_exp;
  logic [ADDR_WIDTH-1:0] w_exp_nx;
  logic                  r_discard;
  logic                  w_discard_nx;
  logic                  r_err;
  logic                  w_err_set;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_issue;
  logic                  w_rsp;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic                  w_unused;

  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;
  logic [ADDR_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [63:0]           r_q_word [QUEUE_DEPTH];

  assign w_full      = (r_count == LP_FULL);
  assign req_valid   = !reset && (r_state == S_FETCH) && !w_full;
  assign w_issue     = req_valid && req_ready;
  assign resp_ready  = !reset && (r_state == S_WAIT);
  assign w_rsp       = resp_ready && resp_valid;
  assign fetch_stall = !reset && (r_state == S_FETCH)
                       && (w_full || !req_ready);
  assign req_address = r_pc;
  assign req_source  = CORE_ID;
  assign fetch_error = r_err;

  assign insn_valid  = (r_count != '0);
  assign insn_pc     = insn_valid ? r_q_pc[r_head] : '0;
  assign insn_word   = insn_valid ? r_q_word[r_head] : '0;
  // A redirect flushes the queue, so a same-cycle pop is void.
  assign w_pop       = insn_valid && insn_ready && !redirect_valid;

  assign w_redir_pc  = {redirect_pc[ADDR_WIDTH-1:3], 3'b000};
  assign w_unused    = ^redirect_pc[2:0];

  // Next-state: fetch/wait sequencing, redirect overrides everything.
  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_exp_nx     = r_exp;
    w_discard_nx = r_discard;
    w_push       = 1'b0;
    w_err_set    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (w_issue) begin
          w_pc_nx    = r_pc + ADDR_WIDTH'(8);
          w_exp_nx   = r_pc;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_rsp) begin
          w_state_nx = S_FETCH;
          if (r_discard) begin
            w_discard_nx = 1'b0;
          end else if (resp_address != r_exp) begin
            w_err_set = 1'b1;
            w_pc_nx   = r_exp;
          end else begin
            w_push = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (redirect_valid) begin
      w_pc_nx   = w_redir_pc;
      w_push    = 1'b0;
      w_err_set = 1'b0;
      if (r_state == S_WAIT) begin
        if (w_rsp) begin
          w_state_nx   = S_FETCH;
          w_discard_nx = 1'b0;
        end else begin
          w_state_nx   = S_WAIT;
          w_discard_nx = 1'b1;
        end
      end else if (w_issue) begin
        // The issued request cannot be retracted; drop its reply.
        w_state_nx   = S_WAIT;
        w_discard_nx = 1'b1;
      end else begin
        w_state_nx = S_FETCH;
      end
    end
  end

  // Control state register with sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_exp     <= '0;
      r_discard <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_exp     <= w_exp_nx;
      r_discard <= w_discard_nx;
      r_err     <= r_err | w_err_set;
    end
  end

  // FIFO pointers and occupancy; flushed on reset or redirect.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_exp;
      r_q_word[r_tail] <= resp_payload;
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// tb_insn_fetch_unit: cache responder plus scoreboards of expected
// request addresses and decoded words, one task per scenario.
module tb_insn_fetch_unit;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [7:0]  req_source;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_address;
  logic [63:0] resp_payload;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_pc;
  logic [63:0] insn_word;
  logic        fetch_stall;
  logic        fetch_error;

  int checks;
  int errors;
  logic [31:0] exp_req[$];
  logic [31:0] exp_insn[$];
  int budget;
  int issued;
  int corrupt_req;
  int corrupt_done;
  int flush_req;
  int flush_seen;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  insn_fetch_unit #(
    .ADDR_WIDTH (32),
    .QUEUE_DEPTH(4),
    .RESET_PC   (RPC),
    .CORE_ID    (8'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_address   (req_address),
    .req_source    (req_source),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_address  (resp_address),
    .resp_payload  (resp_payload),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .insn_valid    (insn_valid),
    .insn_ready    (insn_ready),
    .insn_pc       (insn_pc),
    .insn_word     (insn_word),
    .fetch_stall   (fetch_stall),
    .fetch_error   (fetch_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache model and scoreboard checker. Samples at negedge,
  // drives the cache side 1 time unit after the rising edge.
  task automatic monitor();
    logic        s_req;
    logic        s_rsp;
    logic [31:0] a;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      s_req = req_valid && req_ready;
      s_rsp = resp_valid && resp_ready;
      a     = req_address;
      if (s_req) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_extra got %h want none", a);
        end else begin
          e = exp_req.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL req_addr got %h want %h", a, e);
          end
        end
      end
      if (insn_valid && insn_ready) begin
        checks++;
        if (exp_insn.size() == 0) begin
          errors++;
          $display("FAIL insn_extra got %h want none", insn_pc);
        end else begin
          e = exp_insn.pop_front();
          if (insn_pc !== e || insn_word !== {32'h0, e}) begin
            errors++;
            $display("FAIL insn got %h/%h want %h/%h",
                     insn_pc, insn_word, e, {32'h0, e});
          end
        end
      end
      @(posedge clk);
      #1;
      if (flush_seen != flush_req) begin
        flush_seen = flush_req;
        pend       = 1'b0;
        resp_valid = 1'b0;
        s_req      = 1'b0;
      end
      if (s_rsp) resp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          resp_valid   = 1'b1;
          resp_payload = {32'h0, pend_addr};
          if (corrupt_done < corrupt_req) begin
            corrupt_done++;
            resp_address = 32'h300;
          end else begin
            resp_address = pend_addr;
          end
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (s_req) begin
        pend      = 1'b1;
        pend_cnt  = 1;
        pend_addr = a;
        issued++;
      end
      req_ready = (issued < budget);
    end
  endtask

  task automatic give(input int n);
    budget = issued + n;
  endtask

  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_valid && req_ready && req_address == a) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_req timeout got none want %h", a);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_rsp timeout got 0 want 1");
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_req.size() == 0 && exp_insn.size() == 0) break;
    end
    checks++;
    if (exp_req.size() != 0 || exp_insn.size() != 0) begin
      errors++;
      $display("FAIL %s drain got req=%0d insn=%0d left want 0",
               nm, exp_req.size(), exp_insn.size());
    end
    exp_req.delete();
    exp_insn.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic redirect_now(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_valid !== 1'b0 || resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs got %b%b want 00", req_valid, resp_ready);
    end
    checks++;
    if (req_address !== RPC || req_source !== 8'h00) begin
      errors++;
      $display("FAIL rst_addr got %h/%h want %h/00",
               req_address, req_source, RPC);
    end
    checks++;
    if (insn_valid !== 1'b0 || insn_pc !== '0 || insn_word !== '0) begin
      errors++;
      $display("FAIL rst_insn got %b %h %h want 0 0 0",
               insn_valid, insn_pc, insn_word);
    end
    checks++;
    if (fetch_stall !== 1'b0 || fetch_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got %b%b want 00", fetch_stall, fetch_error);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || req_address !== RPC) begin
      errors++;
      $display("FAIL first_req got %b %h want 1 %h",
               req_valid, req_address, RPC);
    end
  endtask

  task automatic test_stream();
    insn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'h100 + 32'(8 * i));
      exp_insn.push_back(32'h100 + 32'(8 * i));
    end
    give(4);
    drain("stream");
  endtask

  task automatic test_full();
    insn_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_req.push_back(32'h120 + 32'(8 * i));
    give(4);
    for (int i = 0; i < 200 && exp_req.size() != 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    give(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({req_valid, fetch_stall, insn_valid} !== 3'b011) begin
        errors++;
        $display("FAIL full_stall got %b want 011",
                 {req_valid, fetch_stall, insn_valid});
      end
    end
    for (int i = 0; i < 5; i++) exp_insn.push_back(32'h120 + 32'(8 * i));
    exp_req.push_back(32'h140);
    insn_ready = 1'b1;
    drain("full");
  endtask

  task automatic test_redirect_wait();
    insn_ready = 1'b0;
    exp_req.push_back(32'h148);
    exp_req.push_back(32'h150);
    exp_req.push_back(32'h158);
    exp_req.push_back(32'h2000);
    exp_req.push_back(32'h2008);
    exp_insn.push_back(32'h2000);
    exp_insn.push_back(32'h2008);
    give(5);
    wait_req(32'h158);
    @(negedge clk);
    redirect_now(32'h2004);
    checks++;
    if (insn_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush got %b want 0", insn_valid);
    end
    insn_ready = 1'b1;
    drain("redir_wait");
  endtask

  task automatic test_redirect_resp();
    exp_req.push_back(32'h2010);
    exp_req.push_back(32'h3000);
    exp_insn.push_back(32'h3000);
    give(2);
    wait_rsp();
    redirect_now(32'h3000);
    drain("redir_resp");
  endtask

  task automatic test_redirect_req();
    exp_req.push_back(32'h3008);
    exp_req.push_back(32'h4000);
    exp_req.push_back(32'h4008);
    exp_insn.push_back(32'h4000);
    exp_insn.push_back(32'h4008);
    give(3);
    wait_req(32'h3008);
    redirect_now(32'h4000);
    drain("redir_req");
    checks++;
    if (fetch_error !== 1'b0) begin
      errors++;
      $display("FAIL err_clean got %b want 0", fetch_error);
    end
  endtask

  task automatic test_mismatch();
    exp_req.push_back(32'h4010);
    exp_req.push_back(32'h4010);
    exp_req.push_back(32'h4018);
    exp_insn.push_back(32'h4010);
    exp_insn.push_back(32'h4018);
    corrupt_req++;
    give(3);
    drain("mismatch");
    checks++;
    if (fetch_error !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b want 1", fetch_error);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect_now(32'hFFFF_FFFB);
    exp_req.push_back(32'hFFFF_FFF8);
    exp_req.push_back(32'h0);
    exp_insn.push_back(32'hFFFF_FFF8);
    exp_insn.push_back(32'h0);
    give(2);
    drain("wrap");
    checks++;
    if (fetch_error !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b want 1", fetch_error);
    end
  endtask

  task automatic test_reset_wait();
    exp_req.push_back(32'h8);
    give(1);
    wait_req(32'h8);
    @(negedge clk);
    reset = 1'b1;
    flush_req++;
    @(posedge clk);
    #1;
    checks++;
    if ({req_valid, resp_ready, insn_valid, fetch_stall, fetch_error}
        !== 5'b0 || req_address !== RPC) begin
      errors++;
      $display("FAIL rst_wait got %b %h want 00000 %h",
               {req_valid, resp_ready, insn_valid, fetch_stall,
                fetch_error}, req_address, RPC);
    end
    reset = 1'b0;
    exp_req.push_back(RPC);
    exp_insn.push_back(RPC);
    give(1);
    drain("rst_wait");
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    budget         = 0;
    issued         = 0;
    corrupt_req    = 0;
    corrupt_done   = 0;
    flush_req      = 0;
    flush_seen     = 0;
    pend           = 1'b0;
    pend_cnt       = 0;
    pend_addr      = '0;
    reset          = 1'b1;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_address   = '0;
    resp_payload   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    insn_ready     = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_req();
    test_mismatch();
    test_wrap();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
